// File: rtl/maxpool_pkg.sv
// maxpool_pkg: shared element type, loader FSM states and tile geometry for the max-pool feeder
package maxpool_pkg;
  localparam int DEF_BITS = 8;
  localparam int DEF_DIM = 32;
  localparam int DEF_LANES = 4;
  localparam int BEATS_PER_ROW = DEF_DIM / DEF_LANES;
  localparam int BEATS_PER_TILE = DEF_DIM * DEF_DIM / DEF_LANES;
  typedef logic [DEF_BITS-1:0] elem_t;
  typedef enum logic {FILL, FULL} state_t;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/maxpool_tile_loader_tile_bank.sv
// tile_bank: DIM x DIM element register array, one LANES-wide write per beat, full parallel read
module tile_bank
  import maxpool_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int DIM = DEF_DIM,
  parameter int LANES = DEF_LANES,
  localparam int BPR = DIM / LANES,
  localparam int RW = idx_width(DIM),
  localparam int BW = idx_width(BPR)
) (
  input  logic                                 clk,
  input  logic                                 we,
  input  logic [RW-1:0]                        row,
  input  logic [BW-1:0]                        beat,
  input  logic [LANES-1:0][BITS-1:0]           data,
  output logic [DIM-1:0][DIM-1:0][BITS-1:0]    q
);
  // write one beat-aligned group of LANES elements; contents are never reset
  always_ff @(posedge clk)
    for (int r = 0; r < DIM; r++)
      for (int b = 0; b < BPR; b++)
        if (we && row == RW'(r) && beat == BW'(b)) q[r][b*LANES +: LANES] <= data;
endmodule

// File: rtl/maxpool_tile_loader.sv
// maxpool_tile_loader: assembles a raster stream into a full tile for the 2x2 pool stage (MAXPOOL_TILE_LOADER_PINGPONG_EN adds a second bank)
module maxpool_tile_loader
  import maxpool_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int DIM = DEF_DIM,
  parameter int LANES = DEF_LANES
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES-1:0][BITS-1:0]           in_data,
  input  logic                                 in_sof,
  output logic                                 tile_valid,
  input  logic                                 tile_ready,
  output logic [DIM-1:0][DIM-1:0][BITS-1:0]    tile_data,
  output logic                                 err_misalign,
  output logic [15:0]                          tile_count
);
  localparam int BPR = DIM / LANES;
  localparam int RW = idx_width(DIM);
  localparam int BW = idx_width(BPR);
  logic [RW-1:0] row, wrow;
  logic [BW-1:0] beat, wbeat;
  logic accept, at_origin, row_end, wlast, handoff;
  assign accept = in_valid & in_ready;
  assign at_origin = row == '0 && beat == '0;
  assign wrow = in_sof ? '0 : row;
  assign wbeat = in_sof ? '0 : beat;
  assign row_end = wbeat == BW'(BPR - 1);
  assign wlast = row_end && wrow == RW'(DIM - 1);
  assign err_misalign = accept & (in_sof ^ at_origin);
  assign handoff = tile_valid & tile_ready;
  // raster position of the next beat; an sof beat restarts the count from (0,0)
  always_ff @(posedge clk)
    if (rst) begin
      row <= '0;
      beat <= '0;
    end else if (accept) begin
      beat <= row_end ? '0 : wbeat + BW'(1);
      row <= wlast ? '0 : row_end ? wrow + RW'(1) : wrow;
    end
  // tiles handed to the pool stage, free-running wrap
  always_ff @(posedge clk)
    if (rst) tile_count <= '0;
    else if (handoff) tile_count <= tile_count + 16'd1;
`ifdef MAXPOOL_TILE_LOADER_PINGPONG_EN
  logic [1:0] full;
  logic wsel, rsel;
  logic [DIM-1:0][DIM-1:0][BITS-1:0] q0, q1;
  assign in_ready = ~&full;
  assign tile_valid = full[rsel];
  assign tile_data = rsel ? q1 : q0;
  // banks alternate strictly, so a completing write never targets the bank being released
  always_ff @(posedge clk)
    if (rst) begin
      full <= '0;
      wsel <= 1'b0;
      rsel <= 1'b0;
    end else begin
      if (accept && wlast) begin
        full[wsel] <= 1'b1;
        wsel <= ~wsel;
      end
      if (handoff) begin
        full[rsel] <= 1'b0;
        rsel <= ~rsel;
      end
    end
  tile_bank #(.BITS(BITS), .DIM(DIM), .LANES(LANES)) u_bank0 (
    .clk(clk), .we(accept & ~wsel), .row(wrow), .beat(wbeat), .data(in_data), .q(q0)
  );
  tile_bank #(.BITS(BITS), .DIM(DIM), .LANES(LANES)) u_bank1 (
    .clk(clk), .we(accept & wsel), .row(wrow), .beat(wbeat), .data(in_data), .q(q1)
  );
`else
  state_t state;
  assign in_ready = state == FILL;
  assign tile_valid = state == FULL;
  // fill until the final beat lands, then hold the tile until the consumer takes it
  always_ff @(posedge clk)
    if (rst) state <= FILL;
    else if (accept && wlast) state <= FULL;
    else if (handoff) state <= FILL;
  tile_bank #(.BITS(BITS), .DIM(DIM), .LANES(LANES)) u_bank (
    .clk(clk), .we(accept), .row(wrow), .beat(wbeat), .data(in_data), .q(tile_data)
  );
`endif
endmodule

// File: doc/maxpool_tile_loader.md
Name: maxpool_tile_loader

Overview:
- Upstream feeder for the 2x2 max-pool array.
- Accepts a raster-order stream of activation elements, LANES per beat, over a valid/ready handshake.
- Assembles a complete DIM x DIM tile and presents it whole on tile_data, which wires straight to the pool stage's dataIn. The tile is held stable until the consumer accepts it.
- Resynchronises on a start-of-frame marker and flags misaligned frames.

Parameters:
- BITS, 8, element width in bits.
- DIM, 32, tile edge length. Must be even and divisible by LANES.
- LANES, 4, elements per input beat. Power of 2, at most DIM.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  loader can accept a beat.
- in_data  input  [BITS-1:0] x [LANES-1:0]  elements; lane 0 is the lowest column.
- in_sof  input  1  beat carries element (0,0) of a new tile.
- tile_valid  output  1  tile_data holds a complete tile.
- tile_ready  input  1  consumer accepts the tile.
- tile_data  output  [BITS-1:0] x [DIM-1:0][DIM-1:0]  assembled tile, indexed [row][col].
- err_misalign  output  1  one-cycle pulse on a framing error.
- tile_count  output  16  number of tiles handed off; wraps at 2^16.

Behaviour:
- Reset values: in_ready=1, tile_valid=0, err_misalign=0, tile_count=0, row/col counters=0, FSM=FILL. Buffer contents are not reset; tile_data is undefined until the first tile_valid.
- A beat is accepted when in_valid & in_ready.
- An accepted beat writes in_data[k] to buf[row][col+k] for k=0..LANES-1.
- After each accepted beat, col advances by LANES. When col reaches DIM it wraps to 0 and row increments.
- FSM FILL:
  - in_ready=1.
  - The accepted beat at row=DIM-1, col=DIM-LANES is the final beat. It moves the FSM to FULL; tile_valid rises the next cycle (latency: 1 cycle after the final beat).
- FSM FULL:
  - in_ready=0, tile_valid=1, tile_data held stable.
  - On tile_valid & tile_ready: FSM returns to FILL, counters go to 0, tile_count increments, and in_ready=1 from the following cycle.
- in_sof on an accepted beat:
  - The beat is written as position (0,0); the counters restart from there.
  - If the counters were not at (0,0), err_misalign pulses and the partial tile is discarded.
- An accepted beat at counter (0,0) with in_sof=0: err_misalign pulses, but the beat is still stored as (0,0).
- tile_ready while tile_valid=0 is ignored.
- tile_ready may be held high permanently. The tile is still presented for exactly one cycle per handoff.
- rst mid-fill or mid-hold discards all state and returns to the reset values above.
- No combinational path from in_valid to in_ready. in_ready and tile_valid are functions of FSM state only.

Optional Feature:
- Macro: MAXPOOL_TILE_LOADER_PINGPONG_EN.
- Defined: two tile buffers, a write bank and a read bank, with fill overlapping hold.
  - in_ready=0 only when both banks are full.
  - When the write bank completes and the read bank is free (or is released by tile_ready in the same cycle), the banks swap. tile_valid stays high across back-to-back tiles without a bubble.
  - Steady-state throughput: one tile per DIM*DIM/LANES cycles.
- Undefined: single buffer and the FILL/FULL behaviour described above. One idle cycle between handoff and the next fill beat.

Decomposition:
- Shared package maxpool_pkg:
  - elem_t, a BITS-wide element typedef;
  - loader FSM state enum {FILL, FULL};
  - localparams BEATS_PER_ROW = DIM/LANES and BEATS_PER_TILE = DIM*DIM/LANES.
- One natural sub-module, tile_bank: a DIM x DIM register array with a row/col/lane write port and a full parallel read. It is instantiated once, or twice under the macro.

Test Plan (DIM=4, LANES=2, BITS=8 unless noted):
- Reset, then 8 beats with elements 0..15 and in_sof on the first beat, tile_ready=0 -> tile_valid=1 on the cycle after beat 8; tile_data[r][c]=4r+c; in_ready=0; tile_count=0.
- From the held state, assert tile_ready for one cycle -> tile_valid=0 and tile_count=1 next cycle; in_ready=1; tile_data unchanged until overwritten.
- 3 beats, then a beat with in_sof and values 0xA0/0xA1 -> err_misalign pulses once; the following 7 beats complete a tile with tile_data[0][0]=0xA0 and tile_data[0][1]=0xA1.
- First beat after reset with in_sof=0 -> err_misalign pulses on the acceptance cycle; the tile still completes after 8 beats.
- Assert rst after 5 beats -> in_ready=1, tile_valid=0, tile_count=0; a fresh 8-beat tile completes normally.
- PINGPONG_EN, tile_ready tied to 1, 24 continuous beats -> in_ready never drops; 3 handoffs; tile_count=3; each tile correct.
